// File: rtl/curve_lut_ctrl.sv
// ---------------------------------------------------------------------------
// curve_lut_ctrl
//
// Runtime-programmable contrast curve for the luma path. Two 256x8 banks
// form a double-buffered LUT: video reads the active bank while the host
// loads the other (shadow) bank. A committed table only takes effect at the
// next frame start, so a curve change never tears mid-frame.
//
// Ports
//   clk, rst_n              pixel clock, async active-low reset
//   per_frame_vsync/href/clken, per_img_Y
//                           incoming video (vsync high during a frame)
//   post_frame_vsync/href/clken, post_img_Y
//                           outgoing video, 2 clk behind the input
//   cfg_bypass              requested bypass, latched at frame start
//   cfg_wr_en/addr/data     shadow-bank write port
//   cfg_wr_ready            high when shadow writes are being accepted
//   cfg_commit              pulse: swap banks at the next frame start
//   swap_pending            commit accepted, swap not yet performed
//   active_bank             bank currently feeding the pixel path
//   table_valid             at least one swap has completed since reset
// ---------------------------------------------------------------------------
module curve_lut_ctrl #(
   parameter int LUT_DEPTH      = 256,
   parameter bit DEFAULT_BYPASS = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_Y,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic [7:0] post_img_Y,
   input  logic       cfg_bypass,
   input  logic       cfg_wr_en,
   input  logic [7:0] cfg_wr_addr,
   input  logic [7:0] cfg_wr_data,
   output logic       cfg_wr_ready,
   input  logic       cfg_commit,
   output logic       swap_pending,
   output logic       active_bank,
   output logic       table_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_SWAP = 2'd2
   } state_t;

   state_t     state;
   logic       bypass_latch;

   logic       vs_s1;
   logic       href_s1;
   logic       clken_s1;
   logic [7:0] y_s1;
   logic       bank_s1;
   logic       bypass_s1;

   logic       vs_rise;
   logic       wr_accept;
   logic [8:0] wr_index;
   logic [8:0] rd_index;

   // Both banks live in one array; the top index bit selects the bank.
   logic [7:0] lut_mem [0:2*LUT_DEPTH-1];

   // The stage-1 vsync register doubles as the delayed vsync for edge
   // detection, so a frame start is seen for exactly one cycle.
   assign vs_rise   = per_frame_vsync & ~vs_s1;

   // Host writes always target the bank the pixel path is not reading, and
   // are only taken while no swap is queued, so a committed table is frozen.
   assign wr_accept = cfg_wr_en & (state == ST_IDLE);
   assign wr_index  = {~active_bank, cfg_wr_addr};
   assign rd_index  = {bank_s1, y_s1};

   // Bank-swap controller. A commit arms the swap; the swap itself happens
   // on the frame start after the commit cycle, so a commit arriving on the
   // same cycle as a frame start waits a whole frame. The SWAP state lasts
   // one cycle and flips the bank on its way back to IDLE, which keeps the
   // blanking pixels right after the frame start on the old bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cfg_wr_ready <= 1'b1;
         swap_pending <= 1'b0;
         active_bank  <= 1'b0;
         table_valid  <= 1'b0;
         bypass_latch <= DEFAULT_BYPASS;
      end else begin
         case (state)
            ST_IDLE: begin
               if (vs_rise) begin
                  bypass_latch <= cfg_bypass;
               end
               if (cfg_commit) begin
                  state        <= ST_PEND;
                  cfg_wr_ready <= 1'b0;
                  swap_pending <= 1'b1;
               end
            end
            ST_PEND: begin
               if (vs_rise) begin
                  state <= ST_SWAP;
               end
            end
            ST_SWAP: begin
               active_bank  <= ~active_bank;
               table_valid  <= 1'b1;
               bypass_latch <= cfg_bypass;
               swap_pending <= 1'b0;
               cfg_wr_ready <= 1'b1;
               state        <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Shadow-bank write port. RAM contents are deliberately not reset; until
   // the first swap the output is forced to bypass, so stale data never
   // reaches the video.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         lut_mem[wr_index] <= cfg_wr_data;
      end
   end

   // Two-stage pixel pipeline. Stage 1 captures the pixel together with the
   // bank and bypass decision in force on that cycle, so a swap or bypass
   // change can never split a pixel between two settings. Stage 2 performs
   // the table lookup (or passes the pixel through) and realigns the syncs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_s1            <= 1'b0;
         href_s1          <= 1'b0;
         clken_s1         <= 1'b0;
         y_s1             <= 8'd0;
         bank_s1          <= 1'b0;
         bypass_s1        <= 1'b1;
         post_frame_vsync <= 1'b0;
         post_frame_href  <= 1'b0;
         post_frame_clken <= 1'b0;
         post_img_Y       <= 8'd0;
      end else begin
         vs_s1            <= per_frame_vsync;
         href_s1          <= per_frame_href;
         clken_s1         <= per_frame_clken;
         y_s1             <= per_img_Y;
         bank_s1          <= active_bank;
         bypass_s1        <= bypass_latch | ~table_valid;
         post_frame_vsync <= vs_s1;
         post_frame_href  <= href_s1;
         post_frame_clken <= clken_s1;
         post_img_Y       <= bypass_s1 ? y_s1 : lut_mem[rd_index];
      end
   end

endmodule

// File: tb/tb_curve_lut_ctrl.sv
// ---------------------------------------------------------------------------
// tb_curve_lut_ctrl
//
// Self-checking bench for curve_lut_ctrl. A frame-level reference model
// (two plain byte arrays, an active-bank flag, a valid flag, a latched
// bypass and a pending flag) is updated whenever the bench issues a write,
// a commit or a frame start, and gives the expected luma for every pixel.
// ---------------------------------------------------------------------------
module tb_curve_lut_ctrl;

   logic       clk;
   logic       rst_n;
   logic       per_frame_vsync;
   logic       per_frame_href;
   logic       per_frame_clken;
   logic [7:0] per_img_Y;
   logic       post_frame_vsync;
   logic       post_frame_href;
   logic       post_frame_clken;
   logic [7:0] post_img_Y;
   logic       cfg_bypass;
   logic       cfg_wr_en;
   logic [7:0] cfg_wr_addr;
   logic [7:0] cfg_wr_data;
   logic       cfg_wr_ready;
   logic       cfg_commit;
   logic       swap_pending;
   logic       active_bank;
   logic       table_valid;

   int tests_run;
   int tests_failed;

   // Reference model state
   logic [7:0] m_bank [0:1][0:255];
   logic       m_active;
   logic       m_valid;
   logic       m_bypass;
   logic       m_pending;

   // Directed pixels consumed by run_pixels before it falls back to random
   logic [7:0] px_q [$];

   curve_lut_ctrl #(
      .LUT_DEPTH      (256),
      .DEFAULT_BYPASS (1'b1)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .per_frame_vsync  (per_frame_vsync),
      .per_frame_href   (per_frame_href),
      .per_frame_clken  (per_frame_clken),
      .per_img_Y        (per_img_Y),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .post_img_Y       (post_img_Y),
      .cfg_bypass       (cfg_bypass),
      .cfg_wr_en        (cfg_wr_en),
      .cfg_wr_addr      (cfg_wr_addr),
      .cfg_wr_data      (cfg_wr_data),
      .cfg_wr_ready     (cfg_wr_ready),
      .cfg_commit       (cfg_commit),
      .swap_pending     (swap_pending),
      .active_bank      (active_bank),
      .table_valid      (table_valid)
   );

   // Free-running pixel clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected luma: identity while bypassed or before any table is live,
   // otherwise the active curve entry.
   function automatic logic [7:0] model_out(input logic [7:0] y);
      if (m_bypass || !m_valid) return y;
      return m_bank[m_active][y];
   endfunction

   function automatic void model_reset();
      m_active  = 1'b0;
      m_valid   = 1'b0;
      m_bypass  = 1'b1;
      m_pending = 1'b0;
   endfunction

   // One host write; the model drops it while a swap is queued.
   task automatic host_write(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = addr;
      cfg_wr_data = data;
      if (!m_pending) m_bank[!m_active][addr] = data;
      @(negedge clk);
      cfg_wr_en = 1'b0;
   endtask

   // Full shadow-bank load: mode 0 is the inverting curve, mode 1 random.
   task automatic load_table(input int mode);
      logic [7:0] d;
      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         d = (mode == 0) ? 8'(8'hFF - a) : 8'($urandom_range(0, 255));
         cfg_wr_en   = 1'b1;
         cfg_wr_addr = 8'(a);
         cfg_wr_data = d;
         if (!m_pending) m_bank[!m_active][a] = d;
      end
      @(negedge clk);
      cfg_wr_en = 1'b0;
   endtask

   task automatic do_commit();
      @(negedge clk);
      cfg_commit = 1'b1;
      m_pending  = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
   endtask

   // Raise vsync and hold three blanking cycles. A swap armed before this
   // frame start takes effect; a commit on the same cycle only arms.
   task automatic frame_start(input bit with_commit);
      @(negedge clk);
      per_frame_vsync = 1'b1;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      if (m_pending) begin
         m_active  = !m_active;
         m_valid   = 1'b1;
         m_pending = 1'b0;
      end else if (with_commit) begin
         m_pending = 1'b1;
      end
      m_bypass = cfg_bypass;
      if (with_commit) cfg_commit = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic end_frame();
      @(negedge clk);
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Stream n pixels back to back and compare each against the model two
   // clocks later, including the delayed sync signals.
   task automatic run_pixels(input int n, input string name);
      logic [10:0] exp_q [$];
      logic [10:0] e;
      logic [10:0] act;
      logic [7:0]  y;
      logic        ce;
      for (int k = 0; k < n + 2; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            e   = exp_q.pop_front();
            act = {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y};
            tests_run++;
            if (act !== e) begin
               tests_failed++;
               $display("[TB] FAIL %s pixel %0d: got vs/href/ce/Y=%b/%b/%b/%h expected %b/%b/%b/%h",
                        name, k - 2, act[10], act[9], act[8], act[7:0],
                        e[10], e[9], e[8], e[7:0]);
            end
         end
         if (k < n) begin
            y  = (px_q.size() > 0) ? px_q.pop_front() : 8'($urandom_range(0, 255));
            ce = (px_q.size() > 0) ? 1'b1 : 1'($urandom_range(0, 1));
            per_img_Y       = y;
            per_frame_href  = 1'b1;
            per_frame_clken = ce;
            exp_q.push_back({per_frame_vsync, 1'b1, ce, model_out(y)});
         end else begin
            per_frame_href  = 1'b0;
            per_frame_clken = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y} !== 11'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_post: got %h expected 000",
                  {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y});
      end
      tests_run++;
      if ({cfg_wr_ready, swap_pending, active_bank, table_valid} !== 4'b1000) begin
         tests_failed++;
         $display("[TB] FAIL reset_status: got ready/pend/bank/valid=%b expected 1000",
                  {cfg_wr_ready, swap_pending, active_bank, table_valid});
      end
      rst_n = 1'b1;
      model_reset();
      cfg_bypass = 1'b0;
      frame_start(1'b0);
      @(negedge clk);
      per_img_Y       = 8'h40;
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      @(negedge clk);
      per_img_Y       = 8'h00;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({post_frame_clken, post_img_Y} !== {1'b1, 8'h40}) begin
         tests_failed++;
         $display("[TB] FAIL reset_bypass_pixel: got ce/Y=%b/%h expected 1/40",
                  post_frame_clken, post_img_Y);
      end
      tests_run++;
      if (active_bank !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_active_bank: got %b expected 0", active_bank);
      end
      end_frame();
   endtask

   task automatic test_swap();
      load_table(0);
      do_commit();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if ({swap_pending, cfg_wr_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL swap_pending_wait: got pend/ready=%b%b expected 10",
                     swap_pending, cfg_wr_ready);
         end
      end
      frame_start(1'b0);
      tests_run++;
      if ({active_bank, table_valid, swap_pending, cfg_wr_ready} !== 4'b1101) begin
         tests_failed++;
         $display("[TB] FAIL swap_status: got bank/valid/pend/ready=%b expected 1101",
                  {active_bank, table_valid, swap_pending, cfg_wr_ready});
      end
      px_q.push_back(8'h10);
      px_q.push_back(8'h00);
      px_q.push_back(8'hFF);
      run_pixels(3, "swap_directed");
      run_pixels(16, "swap_random");
      end_frame();
   endtask

   task automatic test_mid_frame_commit();
      load_table(1);
      frame_start(1'b0);
      run_pixels(12, "midframe_before");
      do_commit();
      run_pixels(12, "midframe_after_commit");
      tests_run++;
      if (active_bank !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL midframe_bank_held: got %b expected 1", active_bank);
      end
      end_frame();
      frame_start(1'b0);
      run_pixels(12, "midframe_next_frame");
      tests_run++;
      if (active_bank !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midframe_bank_swapped: got %b expected 0", active_bank);
      end
      end_frame();
   endtask

   task automatic test_pending_write_drop();
      do_commit();
      @(negedge clk);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = 8'h10;
      cfg_wr_data = 8'h55;
      #1;
      tests_run++;
      if (cfg_wr_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL pend_wr_ready: got %b expected 0", cfg_wr_ready);
      end
      @(negedge clk);
      cfg_wr_en = 1'b0;
      frame_start(1'b0);
      px_q.push_back(8'h10);
      run_pixels(4, "pend_dropped_write");
      end_frame();
      load_table(1);
      do_commit();
      frame_start(1'b0);
      px_q.push_back(8'h10);
      run_pixels(8, "pend_swap_back");
      end_frame();
   endtask

   task automatic test_bypass_mid_frame();
      frame_start(1'b0);
      run_pixels(8, "bypass_before");
      cfg_bypass = 1'b1;
      run_pixels(8, "bypass_ignored_midframe");
      end_frame();
      frame_start(1'b0);
      run_pixels(8, "bypass_active");
      end_frame();
      cfg_bypass = 1'b0;
      frame_start(1'b0);
      run_pixels(8, "bypass_cleared");
      end_frame();
   endtask

   task automatic test_commit_at_vs_rise();
      load_table(1);
      frame_start(1'b1);
      tests_run++;
      if (swap_pending !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL vsrise_commit_pending: got %b expected 1", swap_pending);
      end
      run_pixels(10, "vsrise_commit_old_bank");
      end_frame();
      frame_start(1'b0);
      run_pixels(10, "vsrise_commit_new_bank");
      end_frame();
   endtask

   task automatic test_reset_in_pend();
      load_table(1);
      do_commit();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({swap_pending, active_bank, table_valid, cfg_wr_ready} !== 4'b0001) begin
         tests_failed++;
         $display("[TB] FAIL async_reset_pend: got pend/bank/valid/ready=%b expected 0001",
                  {swap_pending, active_bank, table_valid, cfg_wr_ready});
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      frame_start(1'b0);
      tests_run++;
      if ({active_bank, table_valid} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL reset_swap_lost: got bank/valid=%b expected 00",
                  {active_bank, table_valid});
      end
      run_pixels(10, "reset_forced_bypass");
      end_frame();
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 8; f++) begin
         int nw;
         nw = $urandom_range(0, 12);
         for (int w = 0; w < nw; w++)
            host_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 2) == 0) do_commit();
         cfg_bypass = 1'($urandom_range(0, 3) == 0);
         frame_start(1'($urandom_range(0, 3) == 0));
         run_pixels(10, "random_frame_a");
         if ($urandom_range(0, 2) == 0) do_commit();
         cfg_bypass = 1'($urandom_range(0, 1));
         run_pixels(10, "random_frame_b");
         end_frame();
      end
   endtask

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      rst_n           = 1'b0;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      per_img_Y       = 8'd0;
      cfg_bypass      = 1'b0;
      cfg_wr_en       = 1'b0;
      cfg_wr_addr     = 8'd0;
      cfg_wr_data     = 8'd0;
      cfg_commit      = 1'b0;
      model_reset();

      test_reset();
      test_swap();
      test_mid_frame_commit();
      test_pending_write_drop();
      test_bypass_mid_frame();
      test_commit_at_vs_rise();
      test_reset_in_pend();
      test_back_to_back();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
